// File: rtl/serial_pad_reader_if.sv
// Pad-reader bus: poll control, serial pad lines and decoded button state.
// The master side (host/bench) drives the control and pad data; the reader is the slave.
interface serial_pad_reader_if #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NCH   = 2
);
  logic                  en;
  logic                  trigger;
  logic [NCH-1:0]        pad_data;
  logic                  pad_latch;
  logic                  pad_clk;
  logic [NCH*NBITS-1:0]  buttons;
  logic [NCH*NBITS-1:0]  pressed;
  logic                  valid;
  logic                  busy;

  modport master (
    output en, trigger, pad_data,
    input  pad_latch, pad_clk, buttons, pressed, valid, busy
  );

  modport slave (
    input  en, trigger, pad_data,
    output pad_latch, pad_clk, buttons, pressed, valid, busy
  );
endinterface

// File: rtl/serial_pad_reader.sv
// NES/SNES-style serial pad reader: latches all pads, clocks NBITS bits out of each,
// and publishes the decoded state with newly-pressed edge pulses once per poll.
module serial_pad_reader #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DIV   = 300,
  parameter int unsigned POLL  = 833333
) (
  input logic                clk_i,
  input logic                rst_ni,
  serial_pad_reader_if.slave bus
);

  localparam int unsigned PW = $clog2(POLL);
  localparam int unsigned TW = $clog2(2 * DIV);
  localparam int unsigned BW = $clog2(NBITS);
  localparam int unsigned NW = NCH * NBITS;

  localparam logic [PW-1:0] PollMax  = PW'(POLL - 1);
  localparam logic [TW-1:0] LatchMax = TW'(2 * DIV - 1);
  localparam logic [TW-1:0] DivMax   = TW'(DIV - 1);
  localparam logic [BW-1:0] BitMax   = BW'(NBITS - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StLow, StHigh, StDone} state_e;

  state_e          state_q;
  logic [PW-1:0]   poll_q;
  logic [TW-1:0]   tmr_q;
  logic [BW-1:0]   bit_q;
  logic [NW-1:0]   samp_q, samp_d;
  logic [NW-1:0]   buttons_q, pressed_q;
  logic            pad_latch_q, pad_clk_q, valid_q, busy_q;

  logic            poll_wrap, start, tmr_last, sample_en;

  always_comb begin
    poll_wrap = bus.en && (poll_q == PollMax);
    // A trigger coinciding with the poll wrap still yields a single start.
    start     = (state_q == StIdle) && (poll_wrap || bus.trigger);
    tmr_last  = (state_q == StLatch) ? (tmr_q == LatchMax) : (tmr_q == DivMax);
    sample_en = ((state_q == StLatch) || (state_q == StHigh)) && tmr_last;
  end

  always_comb begin
    samp_d = samp_q;
    if (sample_en) begin
      for (int c = 0; c < int'(NCH); c++) begin
        samp_d[c * int'(NBITS) + int'(bit_q)] = ~bus.pad_data[c];
      end
    end
  end

  // Free-running poll timer; it keeps counting during transactions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      poll_q <= '0;
    end else if (!bus.en || (poll_q == PollMax)) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      bit_q       <= '0;
      samp_q      <= '0;
      buttons_q   <= '0;
      pressed_q   <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      pressed_q <= '0;
      unique case (state_q)
        StIdle: begin
          tmr_q <= '0;
          bit_q <= '0;
          if (start) begin
            state_q     <= StLatch;
            pad_latch_q <= 1'b1;
            pad_clk_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StLatch: begin
          if (tmr_last) begin
            state_q     <= StLow;
            tmr_q       <= '0;
            bit_q       <= BW'(1);
            samp_q      <= samp_d;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StLow: begin
          if (tmr_last) begin
            state_q   <= StHigh;
            tmr_q     <= '0;
            pad_clk_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StHigh: begin
          if (tmr_last) begin
            tmr_q  <= '0;
            samp_q <= samp_d;
            if (bit_q == BitMax) begin
              state_q   <= StDone;
              buttons_q <= samp_d;
              pressed_q <= samp_d & ~buttons_q;
              valid_q   <= 1'b1;
            end else begin
              state_q   <= StLow;
              pad_clk_q <= 1'b0;
              bit_q     <= bit_q + 1'b1;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pad_latch = pad_latch_q;
  assign bus.pad_clk   = pad_clk_q;
  assign bus.buttons   = buttons_q;
  assign bus.pressed   = pressed_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_pad_reader.sv
// Directed bench for serial_pad_reader: an 8-bit/2-pad instance on auto-poll and trigger,
// plus a 16-bit/1-pad instance driven by trigger only. Pads are modelled as shift registers.
module tb_serial_pad_reader;

  localparam int unsigned NB  = 8;
  localparam int unsigned NC  = 2;
  localparam int unsigned DV  = 2;
  localparam int unsigned PL  = 64;
  localparam int unsigned NB2 = 16;
  localparam int unsigned NC2 = 1;
  localparam int unsigned PL2 = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  serial_pad_reader_if #(.NBITS(NB),  .NCH(NC))  bus  ();
  serial_pad_reader_if #(.NBITS(NB2), .NCH(NC2)) bus2 ();

  serial_pad_reader #(.NBITS(NB), .NCH(NC), .DIV(DV), .POLL(PL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  serial_pad_reader #(.NBITS(NB2), .NCH(NC2), .DIV(DV), .POLL(PL2)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus2)
  );

  always #5 clk = ~clk;

  // Pad model: 1 = pressed; pad drives ~press[idx], idx advances on each pad_clk rise.
  logic [7:0]  press0, press1;
  logic [15:0] press2;
  int   idx1 = 0, idx2 = 0;
  logic pclk1_prev = 1'b1, pclk2_prev = 1'b1;

  always @(negedge clk) begin
    if (bus.pad_latch) idx1 <= 0;
    else if (bus.pad_clk && !pclk1_prev) idx1 <= idx1 + 1;
    pclk1_prev <= bus.pad_clk;
    if (bus2.pad_latch) idx2 <= 0;
    else if (bus2.pad_clk && !pclk2_prev) idx2 <= idx2 + 1;
    pclk2_prev <= bus2.pad_clk;
  end

  assign bus.pad_data[0]  = (idx1 < int'(NB))  ? ~press0[idx1] : 1'b1;
  assign bus.pad_data[1]  = (idx1 < int'(NB))  ? ~press1[idx1] : 1'b1;
  assign bus2.pad_data[0] = (idx2 < int'(NB2)) ? ~press2[idx2] : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called on the cycle after pad_latch rises; runs until the next rise (or a bound).
  task automatic measure_poll(output int period, output int lat_hi, output int clk_lo,
                              output int falls, output int tv, output int vcnt, output int pcnt,
                              output logic [15:0] cap_b, output logic [15:0] cap_p,
                              output logic cap_busy);
    logic prev_lat, prev_clk;
    int   t;
    prev_lat = 1'b1; prev_clk = 1'b1; t = 0;
    lat_hi = 0; clk_lo = 0; falls = 0; tv = -1; vcnt = 0; pcnt = 0;
    cap_b = 'x; cap_p = 'x; cap_busy = 1'bx;
    do begin
      if (bus.pad_latch) lat_hi++;
      if (!bus.pad_clk) clk_lo++;
      if (prev_clk && !bus.pad_clk) falls++;
      if (bus.pressed != '0) pcnt++;
      if (bus.valid) begin
        vcnt++; tv = t; cap_b = bus.buttons; cap_p = bus.pressed; cap_busy = bus.busy;
      end
      prev_clk = bus.pad_clk;
      prev_lat = bus.pad_latch;
      tick();
      t++;
    end while (!(bus.pad_latch && !prev_lat) && t < 200);
    period = t;
  endtask

  initial begin
    int period, lat_hi, clk_lo, falls, tv, vcnt, pcnt, t, rises, act;
    logic [15:0] cap_b, cap_p;
    logic cap_busy, prev_lat, prev_clk;

    bus.en = 1'b0; bus.trigger = 1'b0; bus2.en = 1'b0; bus2.trigger = 1'b0;
    press0 = 8'h01; press1 = 8'h00; press2 = 16'h8001;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pad_latch", bus.pad_latch, 0);
    chk("rst_pad_clk",   bus.pad_clk,   1);
    chk("rst_buttons",   bus.buttons,   0);
    chk("rst_pressed",   bus.pressed,   0);
    chk("rst_valid",     bus.valid,     0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_pad_clk2",  bus2.pad_clk,  1);

    // Poll 1: auto-poll timing and first decode
    @(negedge clk);
    rst_n = 1'b1; bus.en = 1'b1;
    t = 0;
    while (!bus.pad_latch && t < 200) begin tick(); t++; end
    chk("first_latch_delay", t, 64);
    measure_poll(period, lat_hi, clk_lo, falls, tv, vcnt, pcnt, cap_b, cap_p, cap_busy);
    chk("p1_latch_high", lat_hi, 4);
    chk("p1_clk_low_cycles", clk_lo, 14);
    chk("p1_clk_pulses", falls, 7);
    chk("p1_valid_time", tv, 32);
    chk("p1_valid_count", vcnt, 1);
    chk("p1_pressed_cycles", pcnt, 1);
    chk("p1_buttons", cap_b, 16'h0001);
    chk("p1_pressed", cap_p, 16'h0001);
    chk("p1_busy_in_done", cap_busy, 1);
    chk("p1_period", period, 64);

    // Poll 2: same stimulus, nothing newly pressed
    measure_poll(period, lat_hi, clk_lo, falls, tv, vcnt, pcnt, cap_b, cap_p, cap_busy);
    chk("p2_buttons", cap_b, 16'h0001);
    chk("p2_pressed", cap_p, 16'h0000);
    chk("p2_valid_count", vcnt, 1);
    chk("p2_period", period, 64);

    // Poll 3: pad 0 released, pad 1 bit 7 pressed
    press0 = 8'h00; press1 = 8'h80;
    measure_poll(period, lat_hi, clk_lo, falls, tv, vcnt, pcnt, cap_b, cap_p, cap_busy);
    chk("p3_buttons", cap_b, 16'h8000);
    chk("p3_pressed", cap_p, 16'h8000);
    chk("p3_valid_time", tv, 32);

    // Reset during bit-3 HIGH of poll 4
    prev_clk = 1'b1; rises = 0; t = 0;
    while (rises < 3 && t < 100) begin
      tick(); t++;
      if (bus.pad_clk && !prev_clk) rises++;
      prev_clk = bus.pad_clk;
    end
    chk("mid_rst_reached_bit3", rises, 3);
    rst_n = 1'b0; bus.en = 1'b0;
    #1;
    chk("mid_rst_busy",      bus.busy,      0);
    chk("mid_rst_pad_clk",   bus.pad_clk,   1);
    chk("mid_rst_pad_latch", bus.pad_latch, 0);
    chk("mid_rst_buttons",   bus.buttons,   0);
    chk("mid_rst_valid",     bus.valid,     0);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.pad_latch || bus.valid || bus.busy) act++;
    end
    chk("no_activity_en0", act, 0);

    // Trigger with en=0: one transaction; triggers while busy and in DONE are ignored
    press0 = 8'h5A; press1 = 8'h3C;
    @(negedge clk);
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    chk("trig_latch", bus.pad_latch, 1);
    chk("trig_busy",  bus.busy,      1);
    prev_lat = 1'b1; rises = 1; vcnt = 0; tv = -1; cap_b = 'x; cap_p = 'x;
    for (int i = 1; i <= 150; i++) begin
      tick();
      bus.trigger = (i == 10);
      if (bus.pad_latch && !prev_lat) rises++;
      prev_lat = bus.pad_latch;
      if (bus.valid) begin
        vcnt++; tv = i; cap_b = bus.buttons; cap_p = bus.pressed;
        bus.trigger = 1'b1;
      end
    end
    bus.trigger = 1'b0;
    chk("trig_latch_rises", rises, 1);
    chk("trig_valid_count", vcnt, 1);
    chk("trig_valid_time", tv, 32);
    chk("trig_buttons", cap_b, 16'h3C5A);
    chk("trig_pressed", cap_p, 16'h3C5A);

    // 16-bit single-pad instance
    @(negedge clk);
    bus2.trigger = 1'b1;
    tick();
    bus2.trigger = 1'b0;
    chk("s16_latch", bus2.pad_latch, 1);
    prev_clk = 1'b1; falls = 0; t = 0;
    while (!bus2.valid && t < 200) begin
      if (prev_clk && !bus2.pad_clk) falls++;
      prev_clk = bus2.pad_clk;
      tick(); t++;
    end
    chk("s16_valid_time", t, 64);
    chk("s16_clk_pulses", falls, 15);
    chk("s16_buttons", bus2.buttons, 16'h8001);
    chk("s16_pressed", bus2.pressed, 16'h8001);
    tick();
    chk("s16_valid_drop", bus2.valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
